fsm_countdown: RTL and testbench



---
 rtl/fsm_countdown.sv | 127 ++++++++++++
 tb/tb_fsm_countdown.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_countdown.sv
// fsm_countdown: debounced-button countdown sequencer with a one-cycle divider tick enable.
// States: IDLE (led=0, waiting for a press) | COUNTING (led steps down once per tick, done_sig on expiry).
module fsm_countdown #(
  parameter int unsigned CLK_DIV         = 1500000,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter logic [3:0]  START_COUNT     = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_btn,
  output logic [3:0] led,
  output logic       busy,
  output logic       done_sig
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    RSVD2    = 2'd2,
    RSVD3    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             go_stable_q, go_stable_d;
  logic             go_prev_q, go_prev_d;
  logic             go_sync;
  logic             go_press;
  logic             tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      led_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      go_stable_q <= 1'b0;
      go_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_cnt_q   <= div_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      go_stable_q <= go_stable_d;
      go_prev_q   <= go_prev_d;
    end
  end

  always_comb begin
    sync1_d     = go_btn;
    sync2_d     = sync1_q;
    go_sync     = ~sync2_q;
    go_prev_d   = go_stable_q;
    go_stable_d = go_stable_q;
    deb_cnt_d   = '0;
    // Level must disagree with the stable value for a full window before it is accepted.
    if (go_sync != go_stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        go_stable_d = go_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    go_press = go_stable_q & ~go_prev_q;
    tick     = (div_cnt_q == DIV_LAST);

    state_d   = state_q;
    led_d     = led_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div_cnt_d = '0;
    case (state_q)
      IDLE: begin
        led_d  = '0;
        busy_d = 1'b0;
        if (go_press) begin
          led_d   = START_COUNT;
          busy_d  = 1'b1;
          state_d = COUNTING;
        end
      end
      COUNTING: begin
        busy_d = 1'b1;
        if (tick) begin
          if (led_q != 4'd0) begin
            led_d = led_q - 4'd1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign done_sig = done_q;

endmodule

// File: tb/tb_fsm_countdown.sv
// Bench for fsm_countdown: expected per-cycle outputs are queued when stimulus is driven
// and compared on the falling edge of the cycle they refer to.
module tb_fsm_countdown;

  logic       clk = 1'b0;
  logic       rst;
  logic       go_btn;
  logic       go_btn_z;
  logic [3:0] led, led_z;
  logic       busy, busy_z;
  logic       done_sig, done_z;

  always #5 clk = ~clk;

  fsm_countdown #(.CLK_DIV(4), .DEBOUNCE_CYCLES(4), .START_COUNT(4'hF)) dut (
    .clk(clk), .rst(rst), .go_btn(go_btn),
    .led(led), .busy(busy), .done_sig(done_sig)
  );

  fsm_countdown #(.CLK_DIV(4), .DEBOUNCE_CYCLES(4), .START_COUNT(4'h0)) dut_z (
    .clk(clk), .rst(rst), .go_btn(go_btn_z),
    .led(led_z), .busy(busy_z), .done_sig(done_z)
  );

  typedef struct {
    int         cyc;
    bit         sel;
    logic [3:0] led;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    int low_len;
    bit accept;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   cyc_n = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   now, ld, d_cyc;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic push_one(input int c, input bit sel, input logic [3:0] l,
                          input logic b, input logic d);
    exp_t e;
    e.cyc = c; e.sel = sel; e.led = l; e.busy = b; e.done = d;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int a, input int b, input bit sel);
    for (int c = a; c <= b; c++) push_one(c, sel, 4'h0, 1'b0, 1'b0);
  endtask

  // Full run from the load edge: S..0 each held 4 cycles, then done, then idle.
  task automatic run_exp(input int load, input logic [3:0] s, input bit sel, input int tmax);
    int total;
    int v;
    total = (int'(s) + 1) * 4;
    for (int t = 0; t <= total + 1 && t <= tmax; t++) begin
      if (t < total) begin
        v = int'(s) - t / 4;
        push_one(load + t, sel, v[3:0], 1'b1, 1'b0);
      end else if (t == total) begin
        push_one(load + t, sel, 4'h0, 1'b0, 1'b1);
      end else begin
        push_one(load + t, sel, 4'h0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic check_now();
    exp_t e;
    logic [3:0] al;
    logic ab, ad;
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc < cyc_n) begin
        n_err++;
        $display("FAIL stale_expectation cyc=%0d now=%0d", e.cyc, cyc_n);
      end else begin
        al = e.sel ? led_z  : led;
        ab = e.sel ? busy_z : busy;
        ad = e.sel ? done_z : done_sig;
        if (al !== e.led || ab !== e.busy || ad !== e.done) begin
          n_err++;
          $display("FAIL outputs dut%0d cyc=%0d got led=%h busy=%b done=%b want led=%h busy=%b done=%b",
                   e.sel, cyc_n, al, ab, ad, e.led, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic clk_step();
    @(negedge clk);
    check_now();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 3000) begin
      clk_step();
      guard++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    tbl[0] = '{1, 1'b0};
    tbl[1] = '{3, 1'b0};
    tbl[2] = '{4, 1'b1};
    tbl[3] = '{2, 1'b0};
    tbl[4] = '{10, 1'b1};

    rst = 1'b1; go_btn = 1'b1; go_btn_z = 1'b1;
    push_idle(2, 2, 1'b0);
    push_idle(2, 2, 1'b1);
    clk_step(); clk_step();
    rst = 1'b0;

    // Press/glitch table: short lows rejected, 4+ cycle lows start a full run.
    for (int i = 0; i < 5; i++) begin
      now = cyc_n;
      if (tbl[i].accept) begin
        ld = now + 7;
        push_idle(now + 1, now + 6, 1'b0);
        run_exp(ld, 4'hF, 1'b0, 1000);
        push_idle(ld + 66, ld + 75, 1'b0);
      end else begin
        push_idle(now + 1, now + tbl[i].low_len + 12, 1'b0);
      end
      go_btn = 1'b0;
      repeat (tbl[i].low_len) clk_step();
      go_btn = 1'b1;
      drain();
      repeat (4) clk_step();
    end

    // Second press at led=9 must not disturb the run.
    now = cyc_n; ld = now + 7;
    push_idle(now + 1, now + 6, 1'b0);
    run_exp(ld, 4'hF, 1'b0, 1000);
    push_idle(ld + 66, ld + 70, 1'b0);
    go_btn = 1'b0; repeat (4) clk_step(); go_btn = 1'b1;
    while (cyc_n < ld + 24) clk_step();
    go_btn = 1'b0; repeat (4) clk_step(); go_btn = 1'b1;
    drain();
    repeat (4) clk_step();

    // Reset while led=6 clears everything on the next edge, no done pulse.
    now = cyc_n; ld = now + 7;
    push_idle(now + 1, now + 6, 1'b0);
    run_exp(ld, 4'hF, 1'b0, 36);
    push_idle(ld + 37, ld + 60, 1'b0);
    go_btn = 1'b0; repeat (4) clk_step(); go_btn = 1'b1;
    while (cyc_n < ld + 36) clk_step();
    rst = 1'b1; clk_step(); rst = 1'b0;
    drain();
    repeat (4) clk_step();

    // Button held low through reset: one run 7 edges after release, no retrigger.
    now = cyc_n; ld = now + 10;
    push_idle(now + 2, now + 9, 1'b0);
    run_exp(ld, 4'hF, 1'b0, 1000);
    push_idle(ld + 66, ld + 85, 1'b0);
    rst = 1'b1; go_btn = 1'b0;
    repeat (3) clk_step();
    rst = 1'b0;
    drain();
    go_btn = 1'b1;
    repeat (10) clk_step();

    // Back-to-back: second press lands in the cycle right after done_sig.
    now = cyc_n; ld = now + 7; d_cyc = ld + 64;
    push_idle(now + 1, now + 6, 1'b0);
    run_exp(ld, 4'hF, 1'b0, 1000);
    run_exp(d_cyc + 2, 4'hF, 1'b0, 1000);
    push_idle(d_cyc + 2 + 66, d_cyc + 2 + 70, 1'b0);
    go_btn = 1'b0; repeat (6) clk_step(); go_btn = 1'b1;
    while (cyc_n < d_cyc - 5) clk_step();
    go_btn = 1'b0; repeat (6) clk_step(); go_btn = 1'b1;
    drain();
    repeat (4) clk_step();

    // START_COUNT=0 instance: single tick then done.
    now = cyc_n; ld = now + 7;
    push_idle(now + 1, now + 6, 1'b1);
    run_exp(ld, 4'h0, 1'b1, 1000);
    push_idle(ld + 6, ld + 10, 1'b1);
    go_btn_z = 1'b0; repeat (5) clk_step(); go_btn_z = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
